// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: default frame width and the
// receiver FSM state encoding.
package uart_rx_pkg;

  localparam int unsigned DATA_BITS_DEF = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } rx_state_e;

endpackage

// File: rtl/rx_synchronizer.sv
// Two-flop synchronizer for the asynchronous Rx line; resets to the idle
// (high) level so that no edge is seen on reset release.
module rx_synchronizer (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/rx_deserializer.sv
// UART frame deserializer: detects the start edge, samples data/parity/stop
// on externally supplied mid-bit strobes and reports a registered result.
module rx_deserializer
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 serial_in,
  input  logic                 sampling_strobe,
  output logic                 start_detected,
  output logic [DATA_BITS-1:0] received_data,
  output logic                 data_valid,
  output logic                 framing_error,
  output logic                 parity_error,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);

  rx_state_e            r_state;
  logic                 r_rx_d;
  logic [CNT_W-1:0]     r_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bit;
  logic                 w_rx_s;
  logic                 w_par_ok;

  rx_synchronizer u_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (serial_in),
    .o_sync  (w_rx_s)
  );

  // Payload plus parity bit must XOR to 1 for odd parity, 0 for even.
  assign w_par_ok = !PARITY_EN || ((^{r_shift, r_par_bit}) == PARITY_ODD);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_rx_d         <= 1'b1;
      r_cnt          <= '0;
      r_shift        <= '0;
      r_par_bit      <= 1'b0;
      received_data  <= '0;
      start_detected <= 1'b0;
      data_valid     <= 1'b0;
      framing_error  <= 1'b0;
      parity_error   <= 1'b0;
      busy           <= 1'b0;
    end else begin
      r_rx_d         <= w_rx_s;
      start_detected <= 1'b0;
      data_valid     <= 1'b0;
      framing_error  <= 1'b0;
      parity_error   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_rx_d && !w_rx_s) begin
            start_detected <= 1'b1;
            busy           <= 1'b1;
            r_state        <= S_START;
          end
        end
        S_START: begin
          if (sampling_strobe) begin
            if (!w_rx_s) begin
              r_cnt   <= '0;
              r_state <= S_DATA;
            end else begin
              busy    <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        S_DATA: begin
          // Line order is LSB first, so each new bit enters at the MSB.
          if (sampling_strobe) begin
            r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            r_cnt   <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(DATA_BITS - 1)) begin
              r_state <= PARITY_EN ? S_PARITY : S_STOP;
            end
          end
        end
        S_PARITY: begin
          if (sampling_strobe) begin
            r_par_bit <= w_rx_s;
            r_state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (sampling_strobe) begin
            busy          <= 1'b0;
            r_state       <= S_IDLE;
            framing_error <= !w_rx_s;
            parity_error  <= !w_par_ok;
            if (w_rx_s && w_par_ok) begin
              data_valid    <= 1'b1;
              received_data <= r_shift;
            end
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_deserializer.sv
// Scoreboard bench for rx_deserializer: an 8N1 instance and an 8E1 instance
// driven with directed frames; a monitor checks every result pulse.
module tb_rx_deserializer;

  localparam int unsigned BIT_CYC = 16;

  typedef struct packed {
    logic       dv;
    logic       fe;
    logic       pe;
    logic [7:0] data;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, reset_p;
  logic       ser, ser_p, stb, stb_p;
  logic       sd, dv, fe, pe, bsy;
  logic       sd_p, dv_p, fe_p, pe_p, bsy_p;
  logic [7:0] rd, rd_p;

  ev_t q0[$];
  ev_t q1[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  starts0 = 0;
  int  starts1 = 0;
  int  exp_starts0 = 0;
  int  exp_starts1 = 0;

  rx_deserializer #(.DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .reset(reset), .serial_in(ser), .sampling_strobe(stb),
    .start_detected(sd), .received_data(rd), .data_valid(dv),
    .framing_error(fe), .parity_error(pe), .busy(bsy)
  );

  rx_deserializer #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_p (
    .clk(clk), .reset(reset_p), .serial_in(ser_p), .sampling_strobe(stb_p),
    .start_detected(sd_p), .received_data(rd_p), .data_valid(dv_p),
    .framing_error(fe_p), .parity_error(pe_p), .busy(bsy_p)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_ev(input int ch, input ev_t act);
    ev_t e;
    n_vec++;
    if ((ch == 0 && q0.size() == 0) || (ch == 1 && q1.size() == 0)) begin
      n_err++;
      $display("FAIL ch%0d unexpected_event: got dv/fe/pe/data=%b%b%b/%h expected none",
               ch, act.dv, act.fe, act.pe, act.data);
      return;
    end
    e = (ch == 0) ? q0.pop_front() : q1.pop_front();
    if (act !== e) begin
      n_err++;
      $display("FAIL ch%0d event: got dv/fe/pe/data=%b%b%b/%h expected %b%b%b/%h",
               ch, act.dv, act.fe, act.pe, act.data, e.dv, e.fe, e.pe, e.data);
    end
  endtask

  // Monitor: every result pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (sd) starts0++;
      if (dv || fe || pe) check_ev(0, '{dv: dv, fe: fe, pe: pe, data: rd});
    end
    if (!reset_p) begin
      if (sd_p) starts1++;
      if (dv_p || fe_p || pe_p) check_ev(1, '{dv: dv_p, fe: fe_p, pe: pe_p, data: rd_p});
    end
  end

  task automatic drive(input int ch, input logic line, input logic s);
    @(posedge clk);
    #1;
    if (ch == 0) begin
      ser = line;
      stb = s;
    end else begin
      ser_p = line;
      stb_p = s;
    end
  endtask

  task automatic send_bit(input int ch, input logic b);
    for (int i = 0; i < int'(BIT_CYC); i++) drive(ch, b, i == 7);
  endtask

  task automatic send_frame(input int ch, input logic [7:0] data, input logic par,
                            input logic stop, input logic use_par);
    send_bit(ch, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(ch, data[i]);
    if (use_par) send_bit(ch, par);
    send_bit(ch, stop);
  endtask

  task automatic idle(input int ch, input int n);
    for (int i = 0; i < n; i++) drive(ch, 1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b1; reset_p = 1'b1;
    ser = 1'b1; ser_p = 1'b1; stb = 1'b0; stb_p = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pulses_busy", 16'({sd, dv, fe, pe, bsy}), 16'h0);
    check("rst_data", 16'(rd), 16'h0);
    check("rst_pulses_busy_p", 16'({sd_p, dv_p, fe_p, pe_p, bsy_p}), 16'h0);
    check("rst_data_p", 16'(rd_p), 16'h0);
    @(posedge clk); #1;
    reset = 1'b0; reset_p = 1'b0;
    idle(0, 4);

    // Good 8N1 frame
    q0.push_back('{dv: 1'b1, fe: 1'b0, pe: 1'b0, data: 8'hA5});
    exp_starts0++;
    send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b0);
    idle(0, 8);
    check("a5_starts", 16'(starts0), 16'(exp_starts0));

    // Two-cycle low glitch: start seen, false start at strobe
    exp_starts0++;
    drive(0, 1'b0, 1'b0);
    drive(0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(0, 1'b1, 1'b0);
    @(negedge clk);
    check("glitch_busy_start", 16'(bsy), 16'h1);
    drive(0, 1'b1, 1'b1);
    idle(0, 4);
    @(negedge clk);
    check("glitch_busy_idle", 16'(bsy), 16'h0);
    check("glitch_starts", 16'(starts0), 16'(exp_starts0));
    idle(0, 12);

    // Framing error keeps previous payload; line stays low afterwards
    q0.push_back('{dv: 1'b0, fe: 1'b1, pe: 1'b0, data: 8'hA5});
    exp_starts0++;
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) drive(0, 1'b0, 1'b0);
    idle(0, 20);
    check("fe_data_held", 16'(rd), 16'h00A5);
    check("fe_starts", 16'(starts0), 16'(exp_starts0));

    // Reset during data bit 4, strobe asserted alongside reset
    exp_starts0++;
    send_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(0, 1'b1);
    for (int i = 0; i < 5; i++) drive(0, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1; ser = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", 16'(bsy), 16'h0);
    check("midrst_data", 16'(rd), 16'h0);
    idle(0, 20);
    check("midrst_busy_later", 16'(bsy), 16'h0);
    q0.push_back('{dv: 1'b1, fe: 1'b0, pe: 1'b0, data: 8'h5A});
    exp_starts0++;
    send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b0);
    idle(0, 8);

    // Back-to-back frames
    q0.push_back('{dv: 1'b1, fe: 1'b0, pe: 1'b0, data: 8'h01});
    q0.push_back('{dv: 1'b1, fe: 1'b0, pe: 1'b0, data: 8'hFF});
    exp_starts0 += 2;
    send_frame(0, 8'h01, 1'b0, 1'b1, 1'b0);
    send_frame(0, 8'hFF, 1'b0, 1'b1, 1'b0);
    idle(0, 8);
    check("b2b_starts", 16'(starts0), 16'(exp_starts0));
    check("b2b_data_hold", 16'(rd), 16'h00FF);

    // Even parity instance: good, parity error, parity + framing error
    idle(1, 4);
    q1.push_back('{dv: 1'b1, fe: 1'b0, pe: 1'b0, data: 8'h07});
    q1.push_back('{dv: 1'b0, fe: 1'b0, pe: 1'b1, data: 8'h07});
    q1.push_back('{dv: 1'b0, fe: 1'b1, pe: 1'b1, data: 8'h07});
    exp_starts1 += 3;
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
    idle(1, 4);
    send_frame(1, 8'h07, 1'b0, 1'b1, 1'b1);
    idle(1, 4);
    send_frame(1, 8'h07, 1'b0, 1'b0, 1'b1);
    idle(1, 20);
    check("par_starts", 16'(starts1), 16'(exp_starts1));
    check("par_busy", 16'(bsy_p), 16'h0);

    check("q0_drained", 16'(q0.size()), 16'h0);
    check("q1_drained", 16'(q1.size()), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rx_deserializer.md
RX_DESERIALIZER -- requirements
Module: rx_deserializer

Interface
REQ-001 Parameter DATA_BITS, default 8: number of data bits per UART frame, legal range 5..9.
REQ-002 Parameter PARITY_EN, default 0: 1 = one parity bit follows the data bits.
REQ-003 Parameter PARITY_ODD, default 0: 1 = odd parity, 0 = even parity; ignored when PARITY_EN=0.
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 serial_in  input  1  asynchronous UART Rx line, idle high.
REQ-007 sampling_strobe  input  1  one-cycle pulse marking mid-bit sample point, from the strobe generator.
REQ-008 start_detected  output  1  one-cycle pulse on start-bit falling edge, to the strobe generator.
REQ-009 received_data  output  DATA_BITS  last accepted frame payload, LSB = first received bit.
REQ-010 data_valid  output  1  one-cycle pulse: received_data updated with a good frame.
REQ-011 framing_error  output  1  one-cycle pulse: stop bit sampled low.
REQ-012 parity_error  output  1  one-cycle pulse: parity mismatch (PARITY_EN=1 only).
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 serial_in SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rx_s and its 1-cycle delayed copy rx_d.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE: rx_d=1 and rx_s=0 -> start_detected=1 for exactly that cycle, next state START; start_detected SHALL never assert outside IDLE.
REQ-017 sampling_strobe SHALL be ignored in IDLE.
REQ-018 START: on strobe, rx_s=0 -> DATA, bit counter cleared; rx_s=1 -> false start, back to IDLE, no output pulse.
REQ-019 DATA: on each strobe, shift rx_s into MSB of shift register (LSB-first line order), increment counter; after DATA_BITS strobes -> PARITY if PARITY_EN else STOP.
REQ-020 PARITY: on strobe, capture rx_s as the parity bit; -> STOP.
REQ-021 STOP: on strobe -> IDLE; rx_s=1 and parity good -> data_valid=1 and received_data loaded next cycle; rx_s=0 -> framing_error=1, received_data unchanged.
REQ-022 Parity mismatch with stop bit high SHALL pulse parity_error, not data_valid; received_data unchanged.
REQ-023 Framing and parity errors together SHALL pulse both error outputs, no data_valid.
REQ-024 All pulses SHALL be registered, asserted the cycle after the deciding strobe, one cycle wide.
REQ-025 received_data SHALL hold its value until the next data_valid.
REQ-026 After a framing error (line still low), a new start SHALL require rx_s to return high then fall again.
REQ-027 A new falling edge in the cycle IDLE is re-entered SHALL be detected normally (back-to-back frames, no dropped start).

Reset
REQ-028 Reset SHALL force: state IDLE, synchronizer flops and rx_d to 1, counter 0, shift register 0, received_data 0, all pulse outputs 0, busy 0.
REQ-029 Reset mid-frame SHALL abort the frame with no data_valid or error pulse; reset has priority over strobe.

Structure
REQ-030 State encoding localparams and DATA_BITS default SHALL live in shared package uart_rx_pkg.
REQ-031 The 2-flop synchronizer SHALL be sub-module rx_synchronizer (reset value 1).
REQ-032 Bit counter width SHALL be $clog2(DATA_BITS+1).

Verification
REQ-033 Frame 0xA5 (8N1) with strobes mid-bit -> start_detected once, data_valid once, received_data=0xA5, no errors.
REQ-034 Low glitch 2 cycles long, line high at START strobe -> return to IDLE, no data_valid, no errors.
REQ-035 Frame 0x3C with stop bit low -> framing_error once, received_data retains prior 0xA5.
REQ-036 PARITY_EN=1, even, 0x07 with parity bit 0 -> parity_error once, no data_valid.
REQ-037 Reset asserted during DATA bit 4 -> IDLE, busy=0, no pulses; following 0x5A frame received correctly.
REQ-038 Frames 0x01 then 0xFF with no idle gap beyond stop bit -> two data_valid pulses, values 0x01 then 0xFF.
